// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer: opcodes, ALU encodings,
// FSM states and instruction field positions. STEP_WAIT exists only with SEQ_SINGLE_STEP_EN.
package seq_pkg;

  localparam int INSTR_W  = 32;
  localparam int OP_LSB   = 24;
  localparam int DEST_LSB = 16;
  localparam int SRC2_LSB = 8;
  localparam int SRC1_LSB = 0;
  localparam int IMM_LSB  = 0;
  localparam int BYTE_W   = 8;

  localparam logic [7:0] OP_MOV   = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_AND   = 8'h02;
  localparam logic [7:0] OP_OR    = 8'h03;
  localparam logic [7:0] OP_LOADI = 8'h08;
  localparam logic [7:0] OP_SUB   = 8'h09;

  typedef enum logic [2:0] {
    ALU_FWD = 3'b000,
    ALU_ADD = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK
`ifdef SEQ_SINGLE_STEP_EN
    , S_STEP_WAIT
`endif
  } state_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of the instruction register into register addresses,
// immediate and ALU controls; flags undefined opcodes via legal_o.
module instr_decoder
  import seq_pkg::*;
#(
  parameter int RF_AW = 3
) (
  input  logic [31:0]      ir_i,
  output logic [RF_AW-1:0] dest_addr_o,
  output logic [RF_AW-1:0] src2_addr_o,
  output logic [RF_AW-1:0] src1_addr_o,
  output logic [7:0]       imm_o,
  output logic [2:0]       alu_op_o,
  output logic             imm_sel_o,
  output logic             neg_sel_o,
  output logic             legal_o
);

  logic [7:0] opcode;
  logic       unused_fields;

  assign opcode      = ir_i[OP_LSB +: BYTE_W];
  assign dest_addr_o = ir_i[DEST_LSB +: RF_AW];
  assign src2_addr_o = ir_i[SRC2_LSB +: RF_AW];
  assign src1_addr_o = ir_i[SRC1_LSB +: RF_AW];
  assign imm_o       = ir_i[IMM_LSB +: BYTE_W];

  // Upper bits of the dest and src2 bytes carry no meaning.
  assign unused_fields = ^{ir_i[DEST_LSB+BYTE_W-1 : DEST_LSB+RF_AW],
                           ir_i[SRC2_LSB+BYTE_W-1 : SRC2_LSB+RF_AW]};

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    alu_op_o  = ALU_FWD;
    imm_sel_o = 1'b0;
    neg_sel_o = 1'b0;
    legal_o   = 1'b1;
    case (opcode)
      OP_MOV:   alu_op_o = ALU_FWD;
      OP_ADD:   alu_op_o = ALU_ADD;
      OP_AND:   alu_op_o = ALU_AND;
      OP_OR:    alu_op_o = ALU_OR;
      OP_LOADI: imm_sel_o = 1'b1;
      OP_SUB: begin
        alu_op_o  = ALU_ADD;
        neg_sel_o = 1'b1;
      end
      default:  legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multicycle FETCH/DECODE/EXECUTE/WRITEBACK control unit owning the PC.
// Optional SEQ_SINGLE_STEP_EN adds a step input and a STEP_WAIT stall after each instruction.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int PROG_LEN = 8,
  parameter int PC_W     = 3,
  parameter int RF_AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [31:0]      instruction,
  output logic [PC_W-1:0]  Read_Addr,
  output logic [RF_AW-1:0] dest_addr,
  output logic [RF_AW-1:0] src1_addr,
  output logic [RF_AW-1:0] src2_addr,
  output logic [7:0]       imm,
  output logic             imm_sel,
  output logic [2:0]       alu_op,
  output logic             neg_sel,
  output logic             reg_write_en,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  state_e           state_q;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [31:0]      ir_q;
  logic             legal_q;
  logic [RF_AW-1:0] dest_q, src1_q, src2_q;
  logic [7:0]       imm_q;
  logic [2:0]       alu_op_q;
  logic             imm_sel_q, neg_sel_q, we_q, busy_q, done_q, illegal_q;
  logic             last_instr;

  logic [RF_AW-1:0] dec_dest, dec_src1, dec_src2;
  logic [7:0]       dec_imm;
  logic [2:0]       dec_alu_op;
  logic             dec_imm_sel, dec_neg_sel, dec_legal;

  instr_decoder #(.RF_AW(RF_AW)) u_decoder (
    .ir_i        (ir_q),
    .dest_addr_o (dec_dest),
    .src2_addr_o (dec_src2),
    .src1_addr_o (dec_src1),
    .imm_o       (dec_imm),
    .alu_op_o    (dec_alu_op),
    .imm_sel_o   (dec_imm_sel),
    .neg_sel_o   (dec_neg_sel),
    .legal_o     (dec_legal)
  );

  assign last_instr = (pc_q == PC_W'(PROG_LEN - 1));
  assign pc_d       = last_instr ? '0 : pc_q + PC_W'(1);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      legal_q   <= 1'b0;
      dest_q    <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      imm_q     <= '0;
      alu_op_q  <= ALU_FWD;
      imm_sel_q <= 1'b0;
      neg_sel_q <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_FETCH;
          busy_q  <= 1'b1;
        end
        S_FETCH: begin
          ir_q    <= instruction;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          dest_q    <= dec_dest;
          src1_q    <= dec_src1;
          src2_q    <= dec_src2;
          imm_q     <= dec_imm;
          alu_op_q  <= dec_alu_op;
          imm_sel_q <= dec_imm_sel;
          neg_sel_q <= dec_neg_sel;
          legal_q   <= dec_legal;
          illegal_q <= ~dec_legal;
          state_q   <= S_EXECUTE;
        end
        S_EXECUTE: begin
          we_q    <= legal_q;
          done_q  <= last_instr;
          state_q <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          pc_q <= pc_d;
          if (last_instr) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
`ifdef SEQ_SINGLE_STEP_EN
            state_q <= S_STEP_WAIT;
`else
            state_q <= S_FETCH;
`endif
          end
        end
`ifdef SEQ_SINGLE_STEP_EN
        S_STEP_WAIT: if (step) state_q <= S_FETCH;
`endif
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: ir_q carries no reset; FETCH always loads it before DECODE reads it.

  assign Read_Addr    = pc_q;
  assign dest_addr    = dest_q;
  assign src1_addr    = src1_q;
  assign src2_addr    = src2_q;
  assign imm          = imm_q;
  assign imm_sel      = imm_sel_q;
  assign alu_op       = alu_op_q;
  assign neg_sel      = neg_sel_q;
  assign reg_write_en = we_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign illegal      = illegal_q;

endmodule
